// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side memory bus: widths, direction encoding,
// master FSM state type and the read-data gating helper.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic BUS_RW_READ  = 1'b1;
    localparam logic BUS_RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } bus_master_state_t;

    // Writes (and anything not a read) must never leak bus read data upward.
    function automatic logic [DATA_W-1:0] bus_rdata_sel(input logic rw,
                                                        input logic [DATA_W-1:0] rdata);
        return (rw == BUS_RW_READ) ? rdata : '0;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Request/response ports of the bus master plus the responder-facing bus wires.
// master modport is the bus_master view; slave is the CPU/responder side view.
interface bus_master_if;
    import bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic              RW;
    logic              Cmd;
    logic [DATA_W-1:0] RData;
    logic              Finish;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, RData, Finish,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, WData, RW, Cmd
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, rsp_ready, RData, Finish,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, Addr, WData, RW, Cmd
    );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Cycle counter for a pending bus command: cleared when a command starts,
// counts waiting cycles, flags the cycle in which the LIMIT-th wait cycle ends.
module bus_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_reg;
    logic [15:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Asserted while the current wait cycle is the last one allowed.
    assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/bus_master.sv
// Single-outstanding initiator for the 16-bit address / 8-bit data memory bus.
// Optional command timeout is built when BUS_MASTER_TIMEOUT_EN is defined.
module bus_master
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    bus_master_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("bus_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    bus_master_state_t state_reg, state_next;

    logic              req_ready_reg, req_ready_next;
    logic              cmd_reg, cmd_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              rw_reg, rw_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic accept;
    logic timeout_hit;

    assign accept = (state_reg == IDLE) && req_ready_reg && bus.req_valid;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic busy_wait;

    assign busy_wait = (state_reg == BUSY) && !bus.Finish;

    bus_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (busy_wait),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rw_next    = rw_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    addr_next  = bus.req_addr;
                    wdata_next = bus.req_wdata;
                    rw_next    = bus.req_rw;
                end
            end
            BUSY: begin
                // Finish takes priority over a timeout expiring in the same cycle.
                if (bus.Finish) begin
                    state_next = RESP;
                    rdata_next = bus_rdata_sel(rw_reg, bus.RData);
                    err_next   = 1'b0;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    rdata_next = '0;
                    err_next   = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        req_ready_next = (state_next == IDLE);
        cmd_next       = (state_next == BUSY);
        rsp_valid_next = (state_next == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            cmd_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rw_reg        <= BUS_RW_READ;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            cmd_reg       <= cmd_next;
            rsp_valid_reg <= rsp_valid_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rw_reg        <= rw_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.Cmd       = cmd_reg;
    assign bus.Addr      = addr_reg;
    assign bus.WData     = wdata_reg;
    assign bus.RW        = rw_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a 2 KB RAM responder of programmable wait.
// Timeout scenarios run only when BUS_MASTER_TIMEOUT_EN is defined.
module tb_bus_master;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_master_if bus ();

    bus_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: wait_cycles = number of Cmd cycles until Finish (0 = never).
    logic [7:0]  mem [0:2047];
    int          wait_cycles    = 1;
    logic        force_finish   = 1'b0;
    int          cmd_run        = 0;
    int          last_cmd_len   = 0;
    int          cmd_rises      = 0;
    bit          stable_err     = 1'b0;
    bit          ready_busy_err = 1'b0;
    logic [15:0] a_q;
    logic [7:0]  w_q;
    logic        r_q;
    logic        fin;

    always @(negedge clk) begin
        if (bus.Cmd === 1'b1) begin
            if (cmd_run == 0) begin
                cmd_rises = cmd_rises + 1;
                a_q = bus.Addr;
                w_q = bus.WData;
                r_q = bus.RW;
            end else if (bus.Addr !== a_q || bus.WData !== w_q || bus.RW !== r_q) begin
                stable_err = 1'b1;
            end
            cmd_run = cmd_run + 1;
        end else begin
            if (cmd_run != 0) last_cmd_len = cmd_run;
            cmd_run = 0;
        end
        if (bus.req_ready === 1'b1 && (bus.Cmd === 1'b1 || bus.rsp_valid === 1'b1))
            ready_busy_err = 1'b1;
        fin = force_finish || (bus.Cmd === 1'b1 && wait_cycles != 0 && cmd_run == wait_cycles);
        bus.Finish = fin;
        bus.RData  = 8'hEE;
        if (fin && bus.Cmd === 1'b1) begin
            if (bus.RW === 1'b1) bus.RData = mem[bus.Addr[10:0]];
            else                 mem[bus.Addr[10:0]] = bus.WData;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_req(input logic rw, input logic [15:0] a, input logic [7:0] d,
                            input bit hold, output int acc);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) step();
        if (bus.req_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL req_accept: req_ready=%b required 1 within 50 cycles", bus.req_ready);
        end
        step();
        acc = cyc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] rd, output logic er, output int rc);
        for (int i = 0; i < 200 && bus.rsp_valid !== 1'b1; i++) step();
        if (bus.rsp_valid !== 1'b1) begin
            n_checks++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 200 cycles", bus.rsp_valid);
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        rc = cyc;
        $display("rsp addr=%04h rw=%b rdata=%02h err=%b cycle=%0d", bus.Addr, bus.RW, rd, er, rc);
        if (bus.rsp_ready === 1'b1) step();
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.Cmd !== 1'b0) $display("FAIL rst_cmd: got %b want 0", bus.Cmd); else n_pass++;
        n_checks++; if (bus.RW !== 1'b1) $display("FAIL rst_rw: got %b want 1", bus.RW); else n_pass++;
        n_checks++; if (bus.Addr !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", bus.Addr); else n_pass++;
        n_checks++; if (bus.WData !== 8'h00) $display("FAIL rst_wdata: got %h want 00", bus.WData); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata: got %h want 00", bus.rsp_rdata); else n_pass++;
        n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [7:0] rd; logic er; int acc; int rc;
        wait_cycles   = 1;
        bus.rsp_ready = 1'b1;
        send_req(BUS_RW_WRITE, 16'h0123, 8'h5A, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'h00) $display("FAIL zw_write_rdata: got %h want 00", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL zw_write_err: got %b want 0", er); else n_pass++;
        send_req(BUS_RW_READ, 16'h0123, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'h5A) $display("FAIL zw_read_rdata: got %h want 5a", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL zw_read_err: got %b want 0", er); else n_pass++;
        // Accept at edge N, rsp_valid in the cycle after edge N+1 (spec cycle N+2).
        n_checks++; if (rc - acc != 1) $display("FAIL zw_latency: got %0d edges want 1", rc - acc); else n_pass++;
        n_checks++; if (last_cmd_len != 1) $display("FAIL zw_cmd_len: got %0d want 1", last_cmd_len); else n_pass++;
    endtask

    task automatic test_wait_state();
        logic [7:0] rd; logic er; int acc; int rc;
        wait_cycles   = 5;
        stable_err    = 1'b0;
        send_req(BUS_RW_WRITE, 16'h0456, 8'hC3, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (last_cmd_len != 5) $display("FAIL ws_write_cmd_len: got %0d want 5", last_cmd_len); else n_pass++;
        send_req(BUS_RW_READ, 16'h0456, 8'h99, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'hC3) $display("FAIL ws_read_rdata: got %h want c3", rd); else n_pass++;
        n_checks++; if (rc - acc != 5) $display("FAIL ws_latency: got %0d edges want 5", rc - acc); else n_pass++;
        n_checks++; if (last_cmd_len != 5) $display("FAIL ws_read_cmd_len: got %0d want 5", last_cmd_len); else n_pass++;
        n_checks++; if (stable_err !== 1'b0) $display("FAIL ws_bus_stable: got %b want 0", stable_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic er; int rc;
        int acc [3];
        logic [7:0] val;
        int rises0;
        wait_cycles    = 1;
        bus.rsp_ready  = 1'b1;
        ready_busy_err = 1'b0;
        rises0         = cmd_rises;
        for (int i = 0; i < 3; i++) begin
            val = 8'(17 * (i + 1));
            send_req(BUS_RW_WRITE, 16'(16'h0010 + i), val, i < 2, acc[i]);
            wait_rsp(rd, er, rc);
        end
        for (int i = 0; i < 3; i++) begin
            val = 8'(17 * (i + 1));
            send_req(BUS_RW_READ, 16'(16'h0010 + i), 8'h00, i < 2, acc[i]);
            wait_rsp(rd, er, rc);
            n_checks++; if (rd !== val) $display("FAIL b2b_rdata%0d: got %h want %h", i, rd, val); else n_pass++;
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++; if (acc[i] - acc[i-1] != 4) $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc[i] - acc[i-1]); else n_pass++;
        end
        n_checks++; if (cmd_rises - rises0 != 6) $display("FAIL b2b_cmd_pulses: got %0d want 6", cmd_rises - rises0); else n_pass++;
        n_checks++; if (ready_busy_err !== 1'b0) $display("FAIL b2b_ready_outside_idle: got %b want 0", ready_busy_err); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] rd; logic er; int acc; int rc;
        int bad;
        int rises0;
        wait_cycles   = 1;
        bus.rsp_ready = 1'b0;
        send_req(BUS_RW_READ, 16'h0456, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'hC3) $display("FAIL bp_rdata: got %h want c3", rd); else n_pass++;
        bus.req_valid = 1'b1;
        bus.req_rw    = BUS_RW_WRITE;
        bus.req_addr  = 16'h0200;
        bus.req_wdata = 8'h77;
        rises0 = cmd_rises;
        bad    = 0;
        repeat (10) begin
            step();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hC3 || bus.rsp_err !== 1'b0 ||
                bus.Cmd !== 1'b0 || bus.req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        n_checks++; if (cmd_rises != rises0) $display("FAIL bp_no_cmd: got %0d new cmds want 0", cmd_rises - rises0); else n_pass++;
        bus.rsp_ready = 1'b1;
        step();
        send_req(BUS_RW_WRITE, 16'h0200, 8'h77, 1'b0, acc);
        wait_rsp(rd, er, rc);
        send_req(BUS_RW_READ, 16'h0200, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'h77) $display("FAIL bp_pending_write: got %h want 77", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] rd; logic er; int acc; int rc;
        wait_cycles   = 0;
        bus.rsp_ready = 1'b1;
        send_req(BUS_RW_READ, 16'h0456, 8'h00, 1'b0, acc);
        step();
        n_checks++; if (bus.Cmd !== 1'b1) $display("FAIL rmb_cmd_before: got %b want 1", bus.Cmd); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (bus.Cmd !== 1'b0) $display("FAIL rmb_cmd: got %b want 0", bus.Cmd); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmb_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rmb_ready: got %b want 1", bus.req_ready); else n_pass++;
        wait_cycles = 1;
        send_req(BUS_RW_READ, 16'h0123, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (rd !== 8'h5A) $display("FAIL rmb_read_rdata: got %h want 5a", rd); else n_pass++;
        n_checks++; if (rc - acc != 1) $display("FAIL rmb_latency: got %0d edges want 1", rc - acc); else n_pass++;
    endtask

`ifdef BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] rd; logic er; int acc; int rc;
        wait_cycles   = 0;
        bus.rsp_ready = 1'b0;
        send_req(BUS_RW_READ, 16'h0123, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (er !== 1'b1) $display("FAIL to_err: got %b want 1", er); else n_pass++;
        n_checks++; if (rd !== 8'h00) $display("FAIL to_rdata: got %h want 00", rd); else n_pass++;
        n_checks++; if (rc - acc != 8) $display("FAIL to_latency: got %0d edges want 8", rc - acc); else n_pass++;
        n_checks++; if (last_cmd_len != 8) $display("FAIL to_cmd_len: got %0d want 8", last_cmd_len); else n_pass++;
        force_finish = 1'b1;
        step();
        force_finish = 1'b0;
        step();
        n_checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'h00 || bus.rsp_valid !== 1'b1)
            $display("FAIL to_late_finish: got v=%b err=%b rdata=%h want 1 1 00", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        else n_pass++;
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL to_back_idle: got %b want 1", bus.req_ready); else n_pass++;
        wait_cycles = 8;
        send_req(BUS_RW_READ, 16'h0123, 8'h00, 1'b0, acc);
        wait_rsp(rd, er, rc);
        n_checks++; if (er !== 1'b0) $display("FAIL to_finish_wins_err: got %b want 0", er); else n_pass++;
        n_checks++; if (rd !== 8'h5A) $display("FAIL to_finish_wins_rdata: got %h want 5a", rd); else n_pass++;
        n_checks++; if (last_cmd_len != 8) $display("FAIL to_finish_wins_len: got %0d want 8", last_cmd_len); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_state();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_busy();
`ifdef BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
